// File: rtl/idma_dp_req_arbiter.sv
// -----------------------------------------------------------------------------
// idma_dp_req_arbiter
//
// Shares one transport-layer datapath request port between NumReq back-end
// request streams. Requests are granted round-robin. The index of every
// issued request is pushed into an in-order ID FIFO, and each datapath
// response is routed back to the requester at the head of that FIFO.
//
// Handshake semantics (all valid/ready pairs on this block):
//   A transfer happens on a rising clk_i edge where valid & ready are both 1.
//   Once valid is raised it stays high, with its payload stable, until that
//   transfer. Ready may be raised or lowered at any time.
//
// Ports:
//   clk_i           clock
//   rst_i           synchronous active-high reset
//   req_i           request payloads, requester k at [k*ReqWidth +: ReqWidth]
//   req_valid_i     per-requester request valid
//   req_ready_o     per-requester request ready (at most one bit set)
//   dp_req_o        granted request payload to the datapath
//   dp_valid_o      datapath request valid
//   dp_ready_i      datapath request ready
//   dp_rsp_i        datapath response payload
//   dp_rsp_valid_i  datapath response valid
//   dp_rsp_ready_o  datapath response ready
//   rsp_o           response payload, broadcast to all requesters
//   rsp_valid_o     one-hot response valid (bit = requester owning the head)
//   rsp_ready_i     per-requester response ready
//   outstanding_o   ID FIFO fill level (issued, not yet responded)
//   busy_o          any request pending, grant locked or ID outstanding
// -----------------------------------------------------------------------------
module idma_dp_req_arbiter #(
    parameter int unsigned NumReq         = 4,
    parameter int unsigned NumOutstanding = 4,
    parameter int unsigned ReqWidth       = 64,
    parameter int unsigned RspWidth       = 8
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NumReq*ReqWidth-1:0]            req_i,
    input  logic [NumReq-1:0]                     req_valid_i,
    output logic [NumReq-1:0]                     req_ready_o,
    output logic [ReqWidth-1:0]                   dp_req_o,
    output logic                                  dp_valid_o,
    input  logic                                  dp_ready_i,
    input  logic [RspWidth-1:0]                   dp_rsp_i,
    input  logic                                  dp_rsp_valid_i,
    output logic                                  dp_rsp_ready_o,
    output logic [RspWidth-1:0]                   rsp_o,
    output logic [NumReq-1:0]                     rsp_valid_o,
    input  logic [NumReq-1:0]                     rsp_ready_i,
    output logic [$clog2(NumOutstanding+1)-1:0]   outstanding_o,
    output logic                                  busy_o
);

    localparam int unsigned IdxW = $clog2(NumReq);
    localparam int unsigned CntW = $clog2(NumOutstanding + 1);
    localparam int unsigned PtrW = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;

    localparam logic [IdxW:0]   NumReqExt = (IdxW + 1)'(NumReq);
    localparam logic [IdxW-1:0] LastIdx   = IdxW'(NumReq - 1);
    localparam logic [PtrW-1:0] LastPtr   = PtrW'(NumOutstanding - 1);
    localparam logic [CntW-1:0] FullCnt   = CntW'(NumOutstanding);

    // Arbitration state
    logic [IdxW-1:0] rr_ptr_q;
    logic            lock_q;
    logic [IdxW-1:0] lock_idx_q;

    // In-order ID FIFO
    logic [IdxW-1:0] fifo_mem_q [NumOutstanding];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;

    logic            fifo_full;
    logic            fifo_empty;
    logic [IdxW-1:0] head_idx;

    logic            grant_found;
    logic [IdxW-1:0] grant_idx;
    logic [IdxW:0]   cand_sum;
    logic [IdxW-1:0] cand;

    logic [IdxW-1:0] sel_idx;
    logic            sel_valid;
    logic            push;
    logic            pop;

    assign fifo_full  = (count_q == FullCnt);
    assign fifo_empty = (count_q == '0);
    assign head_idx   = fifo_mem_q[rd_ptr_q];

    // Round-robin search starting at rr_ptr_q. The candidate index is formed
    // with one spare bit and folded back once, so wrap-around is exact for
    // non-power-of-2 NumReq.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        cand        = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand_sum = {1'b0, rr_ptr_q} + (IdxW + 1)'(i);
            if (cand_sum >= NumReqExt) begin
                cand_sum = cand_sum - NumReqExt;
            end
            cand = cand_sum[IdxW-1:0];
            if (!grant_found && req_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // A request presented but not accepted pins the grant so the datapath
    // sees a stable payload until its handshake.
    assign sel_idx   = lock_q ? lock_idx_q : grant_idx;
    assign sel_valid = lock_q ? req_valid_i[lock_idx_q] : grant_found;

    // Full blocks issue outright, even if a pop happens this cycle, so the
    // request side never depends on the response side combinationally.
    assign dp_valid_o = sel_valid & ~fifo_full;
    assign dp_req_o   = req_i[32'(sel_idx) * ReqWidth +: ReqWidth];
    assign push       = dp_valid_o & dp_ready_i;

    always_comb begin
        req_ready_o = '0;
        if (push) begin
            req_ready_o[sel_idx] = 1'b1;
        end
    end

    // Responses always belong to the oldest outstanding request.
    always_comb begin
        rsp_valid_o    = '0;
        dp_rsp_ready_o = 1'b0;
        if (!fifo_empty) begin
            rsp_valid_o[head_idx] = dp_rsp_valid_i;
            dp_rsp_ready_o        = rsp_ready_i[head_idx];
        end
    end

    assign rsp_o = dp_rsp_i;
    assign pop   = dp_rsp_valid_i & dp_rsp_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            if (push) begin
                rr_ptr_q <= (sel_idx == LastIdx) ? '0 : sel_idx + IdxW'(1);
                lock_q   <= 1'b0;
            end else if (dp_valid_o) begin
                lock_q     <= 1'b1;
                lock_idx_q <= sel_idx;
            end

            if (push) begin
                wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
            end

            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= sel_idx;
        end
    end

    assign outstanding_o = count_q;
    assign busy_o        = (|req_valid_i) | lock_q | ~fifo_empty;

    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && fifo_full));

    a_no_rsp_empty: assert property (@(posedge clk_i) disable iff (rst_i)
        !(dp_rsp_valid_i && fifo_empty));

    a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (dp_valid_o && !dp_ready_i) |=> $stable(dp_req_o));

    a_ready_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(req_ready_o));

endmodule

// File: tb/tb_idma_dp_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_idma_dp_req_arbiter
//
// Directed bench for idma_dp_req_arbiter. A 4-requester instance carries the
// main scenarios (round-robin order, lock, full FIFO, blocked response head,
// reset mid-operation); a 3-requester instance covers pointer wrap for a
// non-power-of-2 requester count.
// Expected issues and responses are queued by the stimulus; a monitor on the
// falling edge pops and compares each datapath issue and each delivered
// response.
// -----------------------------------------------------------------------------
module tb_idma_dp_req_arbiter;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- 4-requester DUT ----------------
    logic [255:0] req;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [63:0]  dp_req;
    logic         dp_valid;
    logic         dp_ready;
    logic [7:0]   dp_rsp;
    logic         dp_rsp_valid;
    logic         dp_rsp_ready;
    logic [7:0]   rsp;
    logic [3:0]   rsp_valid;
    logic [3:0]   rsp_ready;
    logic [2:0]   outstanding;
    logic         busy;

    idma_dp_req_arbiter #(
        .NumReq(4), .NumOutstanding(4), .ReqWidth(64), .RspWidth(8)
    ) u_dut (
        .clk_i(clk), .rst_i(rst),
        .req_i(req), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .dp_req_o(dp_req), .dp_valid_o(dp_valid), .dp_ready_i(dp_ready),
        .dp_rsp_i(dp_rsp), .dp_rsp_valid_i(dp_rsp_valid), .dp_rsp_ready_o(dp_rsp_ready),
        .rsp_o(rsp), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .outstanding_o(outstanding), .busy_o(busy)
    );

    // ---------------- 3-requester DUT ----------------
    logic [191:0] req3;
    logic [2:0]   req_valid3;
    logic [2:0]   req_ready3;
    logic [63:0]  dp_req3;
    logic         dp_valid3;
    logic         dp_ready3;
    logic [7:0]   dp_rsp3;
    logic         dp_rsp_valid3;
    logic         dp_rsp_ready3;
    logic [7:0]   rsp3;
    logic [2:0]   rsp_valid3;
    logic [2:0]   rsp_ready3;
    logic [2:0]   outstanding3;
    logic         busy3;

    idma_dp_req_arbiter #(
        .NumReq(3), .NumOutstanding(4), .ReqWidth(64), .RspWidth(8)
    ) u_dut3 (
        .clk_i(clk), .rst_i(rst),
        .req_i(req3), .req_valid_i(req_valid3), .req_ready_o(req_ready3),
        .dp_req_o(dp_req3), .dp_valid_o(dp_valid3), .dp_ready_i(dp_ready3),
        .dp_rsp_i(dp_rsp3), .dp_rsp_valid_i(dp_rsp_valid3), .dp_rsp_ready_o(dp_rsp_ready3),
        .rsp_o(rsp3), .rsp_valid_o(rsp_valid3), .rsp_ready_i(rsp_ready3),
        .outstanding_o(outstanding3), .busy_o(busy3)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    logic [1:0]  exp_iss_q[$];   // requester index of each expected issue
    logic [11:0] exp_rsp_q[$];   // {one-hot rsp_valid, payload} per delivery

    logic [1:0]  mon_iss;
    logic [11:0] mon_rsp;

    function automatic logic [63:0] pay(input logic [1:0] k);
        return {48'hC0DE_0000_0000, 14'd0, k};
    endfunction

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (dp_valid && dp_ready) begin
                if (exp_iss_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL issue_unexpected: got req %0h ready %b, expected no issue",
                             dp_req, req_ready);
                end else begin
                    mon_iss = exp_iss_q.pop_front();
                    check("issue_payload", 66'(dp_req), 66'(pay(mon_iss)));
                    check("issue_ready", 66'(req_ready), 66'(4'b0001 << mon_iss));
                end
            end
            if ((rsp_valid & rsp_ready) != 4'b0000) begin
                if (exp_rsp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rsp_unexpected: got valid %b data %0h, expected none",
                             rsp_valid, rsp);
                end else begin
                    mon_rsp = exp_rsp_q.pop_front();
                    check("rsp_route", 66'({rsp_valid, rsp}), 66'(mon_rsp));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        #1;
    endtask

    task automatic send_rsp(input logic [1:0] idx, input logic [7:0] d);
        dp_rsp_valid = 1'b1;
        dp_rsp       = d;
        exp_rsp_q.push_back({4'b0001 << idx, d});
        tick();
        dp_rsp_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        req           = {pay(2'd3), pay(2'd2), pay(2'd1), pay(2'd0)};
        req_valid     = '0;
        dp_ready      = 1'b0;
        dp_rsp        = '0;
        dp_rsp_valid  = 1'b0;
        rsp_ready     = 4'b1111;
        req3          = {pay(2'd2), pay(2'd1), pay(2'd0)};
        req_valid3    = '0;
        dp_ready3     = 1'b0;
        dp_rsp3       = '0;
        dp_rsp_valid3 = 1'b0;
        rsp_ready3    = 3'b111;

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        sample();
        check("reset_outstanding", 66'(outstanding), 66'd0);
        check("reset_busy", 66'(busy), 66'd0);
        check("reset_dp_valid", 66'(dp_valid), 66'd0);
        check("reset_req_ready", 66'(req_ready), 66'd0);
        check("reset_dp_rsp_ready", 66'(dp_rsp_ready), 66'd0);
        check("reset_rsp_valid", 66'(rsp_valid), 66'd0);

        // 1: all valid, ready constant, each response returned the next cycle.
        //    Grants 0,1,2,3,0.
        dp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            req_valid = (c < 5) ? 4'b1111 : 4'b0000;
            if (c < 5) exp_iss_q.push_back(2'(c % 4));
            if (c > 0) begin
                dp_rsp_valid = 1'b1;
                dp_rsp       = 8'(8'h10 + c - 1);
                exp_rsp_q.push_back({4'b0001 << ((c - 1) % 4), 8'(8'h10 + c - 1)});
            end else begin
                dp_rsp_valid = 1'b0;
            end
            tick();
        end
        req_valid    = '0;
        dp_rsp_valid = 1'b0;
        sample();
        check("t1_outstanding_end", 66'(outstanding), 66'd0);
        check("t1_busy_end", 66'(busy), 66'd0);

        // 2: requester 2 stalls five cycles, requester 0 joins at cycle 2.
        //    Pointer is 1, so 2 wins and stays granted; 0 follows.
        dp_ready  = 1'b0;
        req_valid = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            if (c >= 2) req_valid = 4'b0101;
            sample();
            check("t2_hold_payload", 66'(dp_req), 66'(pay(2'd2)));
            check("t2_hold_valid", 66'(dp_valid), 66'd1);
            check("t2_hold_ready", 66'(req_ready), 66'd0);
            tick();
        end
        dp_ready = 1'b1;
        exp_iss_q.push_back(2'd2);
        tick();
        req_valid = 4'b0001;
        exp_iss_q.push_back(2'd0);
        tick();
        req_valid = '0;
        send_rsp(2'd2, 8'h21);
        send_rsp(2'd0, 8'h22);

        // 3: fill the ID FIFO (pointer 1 -> issues 1,2,3,0), then one pop
        //    lets the fifth issue through on the following cycle.
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            exp_iss_q.push_back(2'((1 + i) % 4));
            tick();
        end
        sample();
        check("t3_full_outstanding", 66'(outstanding), 66'd4);
        check("t3_full_dp_valid", 66'(dp_valid), 66'd0);
        check("t3_full_req_ready", 66'(req_ready), 66'd0);
        tick();
        dp_rsp_valid = 1'b1;
        dp_rsp       = 8'h31;
        exp_rsp_q.push_back({4'b0010, 8'h31});
        sample();
        check("t3_pop_cycle_dp_valid", 66'(dp_valid), 66'd0);
        check("t3_pop_cycle_req_ready", 66'(req_ready), 66'd0);
        tick();
        dp_rsp_valid = 1'b0;
        exp_iss_q.push_back(2'd1);
        sample();
        check("t3_after_pop_outstanding", 66'(outstanding), 66'd3);
        check("t3_after_pop_dp_valid", 66'(dp_valid), 66'd1);
        tick();
        req_valid = '0;
        sample();
        check("t3_refill_outstanding", 66'(outstanding), 66'd4);
        send_rsp(2'd2, 8'h32);
        send_rsp(2'd3, 8'h33);
        send_rsp(2'd0, 8'h34);
        send_rsp(2'd1, 8'h35);

        // 4: issue 1,3,0 (pointer 2); requester 3 refuses its response so
        //    the head blocks until it accepts.
        req_valid = 4'b0010; exp_iss_q.push_back(2'd1); tick();
        req_valid = 4'b1000; exp_iss_q.push_back(2'd3); tick();
        req_valid = 4'b0001; exp_iss_q.push_back(2'd0); tick();
        req_valid = '0;
        rsp_ready = 4'b0111;
        send_rsp(2'd1, 8'h41);
        dp_rsp_valid = 1'b1;
        dp_rsp       = 8'h43;
        for (int c = 0; c < 3; c++) begin
            sample();
            check("t4_blocked_dp_rsp_ready", 66'(dp_rsp_ready), 66'd0);
            check("t4_blocked_rsp_valid", 66'(rsp_valid), 66'(4'b1000));
            check("t4_blocked_outstanding", 66'(outstanding), 66'd2);
            tick();
        end
        rsp_ready = 4'b1111;
        exp_rsp_q.push_back({4'b1000, 8'h43});
        tick();
        dp_rsp_valid = 1'b0;
        send_rsp(2'd0, 8'h40);

        // 5: three outstanding plus a lock on requester 3, then reset.
        //    Pointer before reset is 1; after reset valids {0,3} must pick 0.
        req_valid = 4'b1111; exp_iss_q.push_back(2'd1); tick();
        exp_iss_q.push_back(2'd2); tick();
        req_valid = 4'b0001; exp_iss_q.push_back(2'd0); tick();
        req_valid = 4'b1000;
        dp_ready  = 1'b0;
        sample();
        check("t5_pre_outstanding", 66'(outstanding), 66'd3);
        check("t5_pre_dp_req", 66'(dp_req), 66'(pay(2'd3)));
        tick();
        sample();
        check("t5_locked_busy", 66'(busy), 66'd1);
        rst       = 1'b1;
        req_valid = '0;
        dp_ready  = 1'b1;
        tick();
        rst = 1'b0;
        sample();
        check("t5_post_outstanding", 66'(outstanding), 66'd0);
        check("t5_post_busy", 66'(busy), 66'd0);
        check("t5_post_dp_valid", 66'(dp_valid), 66'd0);
        check("t5_post_dp_rsp_ready", 66'(dp_rsp_ready), 66'd0);
        req_valid = 4'b1001;
        exp_iss_q.push_back(2'd0);
        sample();
        check("t5_first_grant", 66'(dp_req), 66'(pay(2'd0)));
        tick();
        req_valid = '0;
        send_rsp(2'd0, 8'h50);

        // 6: NumReq = 3, only requester 2 valid; the pointer wraps 2 -> 0.
        req_valid3 = 3'b100;
        dp_ready3  = 1'b1;
        for (int c = 0; c < 6; c++) begin
            dp_rsp_valid3 = (c > 0);
            dp_rsp3       = 8'(8'h60 + c);
            sample();
            check("t6_dp_valid", 66'(dp_valid3), 66'd1);
            check("t6_dp_req", 66'(dp_req3), 66'(pay(2'd2)));
            check("t6_req_ready", 66'(req_ready3), 66'(3'b100));
            if (c > 0) check("t6_rsp_valid", 66'(rsp_valid3), 66'(3'b100));
            tick();
        end
        req_valid3 = 3'b011;
        sample();
        check("t6_wrap_grant", 66'(req_ready3), 66'(3'b001));
        check("t6_wrap_payload", 66'(dp_req3), 66'(pay(2'd0)));
        tick();
        req_valid3    = '0;
        dp_rsp_valid3 = 1'b1;
        dp_rsp3       = 8'h6F;
        sample();
        check("t6_last_rsp_valid", 66'(rsp_valid3), 66'(3'b001));
        tick();
        dp_rsp_valid3 = 1'b0;
        sample();
        check("t6_outstanding_end", 66'(outstanding3), 66'd0);
        check("t6_busy_end", 66'(busy3), 66'd0);

        // ---------------- final report ----------------
        repeat (2) tick();
        check("exp_iss_q_drained", 66'(exp_iss_q.size()), 66'd0);
        check("exp_rsp_q_drained", 66'(exp_rsp_q.size()), 66'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
